// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the in-order MEM/WB
//   writeback and a long-latency unit (divider/FPU). Pipeline writes always
//   win the slot. LLU results wait in a small in-order FIFO and drain into
//   cycles where the pipeline leaves the slot free. If the FIFO head is denied
//   STARVE_LIMIT consecutive cycles, the pipeline is stalled until the FIFO
//   has drained completely.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   wb_int_we_i/fp_we_i   pipeline integer / float RF write requests
//   wb_rd_i, wb_data_i    pipeline destination register and data
//   llu_valid_i/ready_o   LLU result handshake
//   llu_fp_i/rd_i/data_i  LLU result: target RF, destination register, data
//   stall_pipe_o          freeze IF..MEM and bubble MEM/WB (FORCE state)
//   rf_int_we_o/fp_we_o   registered RF write enables
//   rf_rd_o, rf_data_o    registered RF write address / data
//   fifo_cnt_o            FIFO occupancy, for the hazard unit
//   fsm_state_o           current FSM state (0 IDLE, 1 WAIT, 2 FORCE), debug
//
// Handshake: an LLU result transfers on a rising clk edge where llu_valid_i
// and llu_ready_o are both high. llu_ready_o depends only on the registered
// occupancy, so it has no combinational path from any input. The LLU holds
// its payload stable while valid is high and ready is low.

module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_int_we_i,
  input  logic                     wb_fp_we_i,
  input  logic [4:0]               wb_rd_i,
  input  logic [31:0]              wb_data_i,
  input  logic                     llu_valid_i,
  output logic                     llu_ready_o,
  input  logic                     llu_fp_i,
  input  logic [4:0]               llu_rd_i,
  input  logic [31:0]              llu_data_i,
  output logic                     stall_pipe_o,
  output logic                     rf_int_we_o,
  output logic                     rf_fp_we_o,
  output logic [4:0]               rf_rd_o,
  output logic [31:0]              rf_data_o,
  output logic [$clog2(DEPTH):0]   fifo_cnt_o,
  output logic [1:0]               fsm_state_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [37:0]     mem [DEPTH];
  logic [37:0]     head;
  logic            slot_free;
  logic            push;
  logic            pop;

  // An integer write to x0 does not really use the port, so it frees the slot.
  assign slot_free   = !wb_fp_we_i && !(wb_int_we_i && (wb_rd_i != 5'd0));
  assign llu_ready_o = (cnt < CW'(DEPTH));
  assign push        = llu_valid_i && llu_ready_o;
  assign pop         = slot_free && (cnt != '0);
  assign head        = mem[rd_ptr];

  assign fifo_cnt_o   = cnt;
  assign stall_pipe_o = (state == FORCE);
  assign fsm_state_o  = state;

  always_comb begin
    cnt_nxt = cnt;
    if (push && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!push && pop) cnt_nxt = cnt - CW'(1);
  end

  // Storage is not reset: occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {llu_fp_i, llu_rd_i, llu_data_i};
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt_nxt;
    end
  end

  // Write port: the pipeline has priority. Otherwise the FIFO head drains.
  // A popped integer result for x0 is consumed without a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_int_we_o <= 1'b0;
      rf_fp_we_o  <= 1'b0;
      rf_rd_o     <= '0;
      rf_data_o   <= '0;
    end else if (!slot_free) begin
      rf_int_we_o <= wb_int_we_i && (wb_rd_i != 5'd0);
      rf_fp_we_o  <= wb_fp_we_i;
      rf_rd_o     <= wb_rd_i;
      rf_data_o   <= wb_data_i;
    end else if (pop) begin
      rf_int_we_o <= !head[37] && (head[36:32] != 5'd0);
      rf_fp_we_o  <= head[37];
      rf_rd_o     <= head[36:32];
      rf_data_o   <= head[31:0];
    end else begin
      rf_int_we_o <= 1'b0;
      rf_fp_we_o  <= 1'b0;
      rf_rd_o     <= '0;
      rf_data_o   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // wait_cnt counts consecutive cycles in which a non-empty FIFO is denied
  // the slot. In WAIT the FIFO is never empty, so "no pop" means "denied".
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      IDLE: begin
        wait_cnt_nxt = '0;
        if (push) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt_nxt == '0) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = '0;
        end else if (pop) begin
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WW'(STARVE_LIMIT - 1)) begin
          state_nxt    = FORCE;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WW'(1);
        end
      end
      FORCE: begin
        wait_cnt_nxt = '0;
        // Pushes arriving during FORCE keep cnt_nxt non-zero and extend it.
        if (cnt_nxt == '0) state_nxt = IDLE;
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_int_we_i;
  logic        wb_fp_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        llu_valid_i;
  logic        llu_ready_o;
  logic        llu_fp_i;
  logic [4:0]  llu_rd_i;
  logic [31:0] llu_data_i;
  logic        stall_pipe_o;
  logic        rf_int_we_o;
  logic        rf_fp_we_o;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_data_o;
  logic [1:0]  fifo_cnt_o;
  logic [1:0]  fsm_state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];
  logic [4:0] exp_rd;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb_int_we_i  (wb_int_we_i),
    .wb_fp_we_i   (wb_fp_we_i),
    .wb_rd_i      (wb_rd_i),
    .wb_data_i    (wb_data_i),
    .llu_valid_i  (llu_valid_i),
    .llu_ready_o  (llu_ready_o),
    .llu_fp_i     (llu_fp_i),
    .llu_rd_i     (llu_rd_i),
    .llu_data_i   (llu_data_i),
    .stall_pipe_o (stall_pipe_o),
    .rf_int_we_o  (rf_int_we_o),
    .rf_fp_we_o   (rf_fp_we_o),
    .rf_rd_o      (rf_rd_o),
    .rf_data_o    (rf_data_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .fsm_state_o  (fsm_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rf(input string tag, input logic iwe, input logic fwe,
                          input logic [4:0] rd, input logic [31:0] data);
    check({tag, ".int_we"}, 32'(rf_int_we_o), 32'(iwe));
    check({tag, ".fp_we"},  32'(rf_fp_we_o),  32'(fwe));
    if (iwe || fwe) begin
      check({tag, ".rd"},   32'(rf_rd_o), 32'(rd));
      check({tag, ".data"}, rf_data_o, data);
    end
  endtask

  task automatic check_ctl(input string tag, input logic stall, input logic [1:0] cnt,
                           input logic rdy, input logic [1:0] st);
    check({tag, ".stall"}, 32'(stall_pipe_o), 32'(stall));
    check({tag, ".cnt"},   32'(fifo_cnt_o),   32'(cnt));
    check({tag, ".ready"}, 32'(llu_ready_o),  32'(rdy));
    check({tag, ".state"}, 32'(fsm_state_o),  32'(st));
  endtask

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic iwe, input logic fwe, input logic [4:0] rd, input logic [31:0] d);
    wb_int_we_i = iwe;
    wb_fp_we_i  = fwe;
    wb_rd_i     = rd;
    wb_data_i   = d;
  endtask

  task automatic set_llu(input logic v, input logic fp, input logic [4:0] rd, input logic [31:0] d);
    llu_valid_i = v;
    llu_fp_i    = fp;
    llu_rd_i    = rd;
    llu_data_i  = d;
  endtask

  initial begin
    rst = 1'b1;
    set_wb(0, 0, 0, 0);
    set_llu(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_rf("reset", 0, 0, 0, 0);
    check("reset.rd",   32'(rf_rd_o), 32'd0);
    check("reset.data", rf_data_o,    32'd0);
    check_ctl("reset", 0, 2'd0, 1, 2'd0);
    rst = 1'b0;
    tick();

    // pipeline only
    set_wb(1, 0, 5'd5, 32'hDEADBEEF);
    tick();
    check_rf("wb_int", 1, 0, 5'd5, 32'hDEADBEEF);
    set_wb(0, 1, 5'd6, 32'h12345678);
    tick();
    check_rf("wb_fp", 0, 1, 5'd6, 32'h12345678);
    set_wb(1, 0, 5'd0, 32'h0BADF00D);
    tick();
    check_rf("wb_x0", 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    tick();
    check_rf("wb_idle", 0, 0, 0, 0);

    // LLU result drains into an idle slot, two edges after it is offered
    set_llu(1, 1, 5'd3, 32'h3F800000);
    check("idle.ready_pre", 32'(llu_ready_o), 32'd1);
    tick();
    set_llu(0, 0, 0, 0);
    check_rf("idle.accept", 0, 0, 0, 0);
    check_ctl("idle.accept", 0, 2'd1, 1, 2'd1);
    tick();
    check_rf("idle.drain", 0, 1, 5'd3, 32'h3F800000);
    check_ctl("idle.drain", 0, 2'd0, 1, 2'd0);
    tick();
    check_rf("idle.after", 0, 0, 0, 0);

    // starvation: slot busy every cycle
    set_wb(1, 0, 5'd10, 32'h0000000A);
    set_llu(1, 0, 5'd4, 32'h00000044);
    tick();
    set_llu(0, 0, 0, 0);
    check_ctl("starve.push", 0, 2'd1, 1, 2'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("starve.no_stall", 32'(stall_pipe_o), 32'd0);
      check_rf("starve.wb_wins", 1, 0, 5'd10, 32'h0000000A);
    end
    tick();
    check_ctl("starve.force", 1, 2'd1, 1, 2'd2);
    set_wb(0, 0, 0, 0);
    tick();
    check_rf("starve.drain", 1, 0, 5'd4, 32'h00000044);
    check_ctl("starve.release", 0, 2'd0, 1, 2'd0);

    // full FIFO, held valid, push+pop, ordering
    set_wb(0, 1, 5'd20, 32'h00000020);
    set_llu(1, 0, 5'd7, 32'h00000070);
    exp_q.push_back(5'd7);
    tick();
    set_llu(1, 0, 5'd8, 32'h00000080);
    exp_q.push_back(5'd8);
    tick();
    check_ctl("full.two", 0, 2'd2, 0, 2'd1);
    check_rf("full.wb_fp", 0, 1, 5'd20, 32'h00000020);
    set_llu(1, 0, 5'd9, 32'h00000090);
    tick();
    check_ctl("full.held", 0, 2'd2, 0, 2'd1);
    set_wb(0, 0, 0, 0);
    tick();
    exp_rd = exp_q.pop_front();
    check_rf("full.pop1", 1, 0, exp_rd, 32'h00000070);
    check_ctl("full.pop1", 0, 2'd1, 1, 2'd1);
    exp_q.push_back(5'd9);
    tick();
    set_llu(0, 0, 0, 0);
    exp_rd = exp_q.pop_front();
    check_rf("full.pushpop", 1, 0, exp_rd, 32'h00000080);
    check("full.pushpop.cnt", 32'(fifo_cnt_o), 32'd1);
    tick();
    exp_rd = exp_q.pop_front();
    check_rf("full.pop3", 1, 0, exp_rd, 32'h00000090);
    check_ctl("full.empty", 0, 2'd0, 1, 2'd0);
    check("full.queue_empty", 32'(exp_q.size()), 32'd0);

    // LLU integer result to x0 is popped without a write
    set_llu(1, 0, 5'd0, 32'h00000055);
    tick();
    set_llu(0, 0, 0, 0);
    check("x0.queued", 32'(fifo_cnt_o), 32'd1);
    tick();
    check_rf("x0.drop", 0, 0, 0, 0);
    check_ctl("x0.drop", 0, 2'd0, 1, 2'd0);

    // pipeline write during FORCE still wins; head waits
    set_wb(1, 0, 5'd11, 32'h000000B1);
    set_llu(1, 0, 5'd12, 32'h000000C2);
    tick();
    set_llu(0, 0, 0, 0);
    repeat (4) tick();
    check_ctl("prio.force", 1, 2'd1, 1, 2'd2);
    set_wb(1, 0, 5'd13, 32'h000000D3);
    tick();
    check_rf("prio.wb", 1, 0, 5'd13, 32'h000000D3);
    check_ctl("prio.held", 1, 2'd1, 1, 2'd2);
    set_wb(0, 0, 0, 0);
    tick();
    check_rf("prio.drain", 1, 0, 5'd12, 32'h000000C2);
    check_ctl("prio.release", 0, 2'd0, 1, 2'd0);

    // asynchronous reset with two entries queued
    set_wb(1, 0, 5'd14, 32'h000000E4);
    set_llu(1, 0, 5'd21, 32'h00000021);
    tick();
    set_llu(1, 0, 5'd22, 32'h00000022);
    tick();
    set_llu(0, 0, 0, 0);
    check("rst.queued", 32'(fifo_cnt_o), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_rf("rst.async", 0, 0, 0, 0);
    check("rst.async.rd",   32'(rf_rd_o), 32'd0);
    check("rst.async.data", rf_data_o,    32'd0);
    check_ctl("rst.async", 0, 2'd0, 1, 2'd0);
    set_wb(0, 0, 0, 0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_rf("rst.no_old_write", 0, 0, 0, 0);
      check_ctl("rst.no_old_write", 0, 2'd0, 1, 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
